// File: rtl/subband_pkg.sv
// Shared constants and state type for the subband synthesis combiner.
// Formats: band samples sfix33_En32, gains sfix16_En14, output sfix13_En12.
package subband_pkg;

  localparam int NUM_BANDS = 16;
  localparam int IN_W      = 33;
  localparam int GAIN_W    = 16;
  localparam int OUT_W     = 13;
  localparam int ACC_W     = 53;

  localparam int     UNITY_GAIN  = 16384;
  localparam longint ROUND_CONST = 64'sd8589934592;
  localparam int     SHIFT       = 34;
  localparam int     OUT_MAX     = 4095;
  localparam int     OUT_MIN     = -4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/combiner_round_sat.sv
// Round-half-up and saturate an En46 accumulator down to an sfix13_En12 sample.
// Purely combinational so it can sit on any bank output.
module combiner_round_sat
  import subband_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_in,
  output logic signed [OUT_W-1:0] sample_out
);

  logic signed [ACC_W:0] rounded;
  logic signed [ACC_W:0] shifted;

  // One extra bit of headroom so the rounding add can never wrap.
  always_comb begin
    rounded = $signed({acc_in[ACC_W-1], acc_in}) + $signed((ACC_W+1)'(ROUND_CONST));
    shifted = rounded >>> SHIFT;
    if (shifted > OUT_MAX) begin
      sample_out = OUT_W'(OUT_MAX);
    end else if (shifted < OUT_MIN) begin
      sample_out = OUT_W'(OUT_MIN);
    end else begin
      sample_out = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/subband_combiner.sv
// Reconstructs one full-band sample from a frame of 16 subband samples by
// serially multiplying each band by its programmable gain and accumulating.
module subband_combiner
  import subband_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clk_enable,
  input  logic [NUM_BANDS*IN_W-1:0]     band_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          gain_we,
  input  logic [3:0]                    gain_addr,
  input  logic signed [GAIN_W-1:0]      gain_data,
  output logic signed [OUT_W-1:0]       out_sample,
  output logic                          out_valid
);

  state_t                       state_q, state_d;
  logic [3:0]                   phase_q, phase_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [NUM_BANDS*IN_W-1:0]    frame_q, frame_d;
  logic signed [GAIN_W-1:0]     gain_q [NUM_BANDS];
  logic signed [GAIN_W-1:0]     gain_d [NUM_BANDS];
  logic                         pend_valid_q, pend_valid_d;
  logic [3:0]                   pend_addr_q, pend_addr_d;
  logic signed [GAIN_W-1:0]     pend_data_q, pend_data_d;
  logic signed [OUT_W-1:0]      out_sample_q, out_sample_d;
  logic                         out_valid_q, out_valid_d;

  logic signed [IN_W-1:0]        band_sel;
  logic signed [IN_W+GAIN_W-1:0] product;
  logic signed [ACC_W-1:0]       acc_sum;
  logic signed [OUT_W-1:0]       rounded_sample;

  combiner_round_sat u_round_sat (
    .acc_in     (acc_sum),
    .sample_out (rounded_sample)
  );

  // The result is registered on the edge that adds the last band, so the
  // sample and its valid pulse are visible throughout the OUT cycle.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    acc_d        = acc_q;
    frame_d      = frame_q;
    gain_d       = gain_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    out_sample_d = out_sample_q;
    out_valid_d  = out_valid_q;

    in_ready = (state_q == IDLE);
    band_sel = frame_q[phase_q*IN_W +: IN_W];
    product  = band_sel * gain_q[phase_q];
    acc_sum  = acc_q + ACC_W'(product);

    if (clk_enable) begin
      out_valid_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gain_we) begin
            gain_d[gain_addr] = gain_data;
          end
          if (in_valid) begin
            frame_d = band_in;
            acc_d   = '0;
            phase_d = '0;
            state_d = MAC;
          end
        end
        MAC: begin
          acc_d   = acc_sum;
          phase_d = phase_q + 4'd1;
          if (gain_we) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = gain_addr;
            pend_data_d  = gain_data;
          end
          if (phase_q == 4'(NUM_BANDS-1)) begin
            out_sample_d = rounded_sample;
            out_valid_d  = 1'b1;
            state_d      = OUT;
          end
        end
        OUT: begin
          // A write in this cycle is the newest pending write, so it wins.
          if (gain_we) begin
            gain_d[gain_addr] = gain_data;
          end else if (pend_valid_q) begin
            gain_d[pend_addr_q] = pend_data_q;
          end
          pend_valid_d = 1'b0;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      acc_q        <= '0;
      frame_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        gain_q[i] <= GAIN_W'(UNITY_GAIN);
      end
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      acc_q        <= acc_d;
      frame_q      <= frame_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      for (int i = 0; i < NUM_BANDS; i++) begin
        gain_q[i] <= gain_d[i];
      end
    end
  end

  assign out_sample = out_sample_q;
  assign out_valid  = out_valid_q;

endmodule

// File: doc/subband_combiner.md
Name: subband_combiner

Overview:
- Synthesis-side counterpart of the 16-band analysis bank: accepts one frame of 16 subband samples (one per band) and reconstructs one full-band output sample.
- Applies a programmable per-band gain to each band and sums the results serially, one band per enabled clock, using the same phase-counter style as the analysis filters.
- Rounds and saturates the sum back to the analysis input format (sfix13_En12), so the output can feed the analysis bank input or a DAC path.

Parameters:
NUM_BANDS, 16, number of subbands per frame
IN_W, 33, subband sample width (sfix33_En32)
GAIN_W, 16, gain width (sfix16_En14, unity = 16384)
OUT_W, 13, output width (sfix13_En12)
ACC_W, 53, accumulator width (49-bit product + 4 guard bits)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
clk_enable  in  1  global advance enable; all state frozen when low
band_in  in  NUM_BANDS*IN_W  packed frame, band k at bits [k*IN_W +: IN_W]
in_valid  in  1  frame present on band_in
in_ready  out  1  combiner can accept a frame
gain_we  in  1  gain write strobe
gain_addr  in  4  band index for the gain write
gain_data  in  GAIN_W  new gain value
out_sample  out  OUT_W  reconstructed sample, held until next result
out_valid  out  1  one enabled-cycle pulse when out_sample updates

Behaviour:
- Reset (reset low, asynchronous):
  - State IDLE; phase=0; accumulator=0.
  - in_ready=1, out_valid=0, out_sample=0.
  - All 16 gains = 16384; pending-write register cleared.
- States: IDLE -> MAC -> OUT -> IDLE. Transitions occur only on cycles with clk_enable=1.
- IDLE:
  - in_ready=1.
  - in_valid & clk_enable: latch all 16 bands into the frame register, clear the accumulator, set phase=0, go to MAC.
- MAC:
  - in_ready=0.
  - Each enabled cycle: acc += sext(band[phase]) * gain[phase] (signed 33x16 -> 49 bits, En46). Then phase++.
  - Leave for OUT after phase 15 has been added.
  - The frame register does not change during MAC; band_in may change freely.
- OUT:
  - in_ready=0.
  - Round half-up: add 2^33, then arithmetic shift right by 34 (En46 -> En12).
  - Saturate to [-4096, 4095]. Register the result into out_sample.
  - out_valid=1 for that cycle. Return to IDLE.
- Latency and throughput:
  - Accept at enabled cycle N; out_valid asserted at enabled cycle N+17.
  - One frame per 18 enabled cycles.
- out_valid:
  - Deasserts on the next enabled cycle.
  - If clk_enable drops, out_valid stays frozen high; consumers qualify it with clk_enable.
- Gain writes:
  - In IDLE with clk_enable=1, a write updates gain[gain_addr] immediately; it is visible to a frame accepted in the same cycle only from the next cycle onward.
  - In MAC or OUT, a write goes to a one-entry pending register, and a later write overwrites it (last wins).
  - The pending write is applied on the IDLE entry cycle, so the frame in flight always uses consistent gains.
- in_valid outside IDLE is ignored: no capture, and there is no error flag.
- Reset asserted mid-frame aborts the frame, produces no out_valid, and loses any pending gain write.
- Accumulator overflow is impossible by construction (4 guard bits); saturation happens only at the output.

Decomposition:
- Package subband_pkg holds:
  - NUM_BANDS, IN_W, GAIN_W, OUT_W, ACC_W
  - UNITY_GAIN=16384, ROUND_CONST=2^33, SHIFT=34, OUT_MAX=4095, OUT_MIN=-4096
  - the state enum {IDLE, MAC, OUT}.
- One sub-module, combiner_round_sat, is natural: ACC_W in, OUT_W out, purely combinational round-and-saturate, reusable on other bank outputs.
- The FSM, phase counter, gain registers and MAC stay in subband_combiner.

Test Plan:
- Unity gains, only band3 = 2^30 (0.25), others 0 -> out_sample=1024, out_valid exactly 17 enabled cycles after accept, in_ready low for cycles 1..17.
- Unity gains, band0 = -2^30 -> out_sample=-1024. Unity gains, all bands = 2^31 (0.5, sum 8.0) -> saturates to 4095. All bands = -2^31 -> -4096.
- Rounding: band0 = 2^19 (exactly 0.5 LSB) -> 1. band0 = 2^19-1 -> 0. band0 = -2^19 -> 0 (half-up).
- Gain write in IDLE gain[5]=8192, band5 = 2^31 -> 1024. Write gain[5]=0 during MAC of the next frame (band5 = 2^31 again) -> that frame still gives 1024; the following frame gives 0.
- clk_enable toggled 50% during MAC -> same result, delivered after 17 enabled cycles. Reset pulsed at phase 8 -> no out_valid, out_sample=0, in_ready=1, gains back to unity.
- in_valid held high continuously with changing band_in -> exactly one capture per 18 enabled cycles, and each output matches the frame sampled on its accept cycle.
